// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel scheduler: source modes, bar colors, default raster size.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_STREAM = 2'd1,
        MODE_WIN    = 2'd2,
        MODE_BLACK  = 2'd3
    } mode_e;

    localparam logic [23:0] BAR_C0 = 24'hFFFFFF;
    localparam logic [23:0] BAR_C1 = 24'hFFFF00;
    localparam logic [23:0] BAR_C2 = 24'h00FFFF;
    localparam logic [23:0] BAR_C3 = 24'h00FF00;
    localparam logic [23:0] BAR_C4 = 24'hFF00FF;
    localparam logic [23:0] BAR_C5 = 24'hFF0000;
    localparam logic [23:0] BAR_C6 = 24'h0000FF;
    localparam logic [23:0] BAR_C7 = 24'h000000;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_C0;
            3'd1:    return BAR_C1;
            3'd2:    return BAR_C2;
            3'd3:    return BAR_C3;
            3'd4:    return BAR_C4;
            3'd5:    return BAR_C5;
            3'd6:    return BAR_C6;
            default: return BAR_C7;
        endcase
    endfunction

endpackage

// File: rtl/vga_bar_pattern.sv
// Eight-bar test pattern: tracks position within the current bar without a divider.
module vga_bar_pattern
    import vga_pkg::*;
#(
    parameter int BAR_W = 80
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Adv_i,
    input  logic        Restart_i,
    output logic [23:0] Color_o
);

    localparam int CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [CW-1:0] cnt_q, cnt_d, cnt_cur;
    logic [2:0]    idx_q, idx_d, idx_cur;

    // Restart marks the current pixel as x=0, so it is colored from bar 0 in the same cycle.
    always_comb begin
        cnt_cur = Restart_i ? '0 : cnt_q;
        idx_cur = Restart_i ? '0 : idx_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (Adv_i) begin
            if (cnt_cur == CW'(BAR_W - 1)) begin
                cnt_d = '0;
                idx_d = idx_cur + 3'd1;
            end else begin
                cnt_d = cnt_cur + 1'b1;
                idx_d = idx_cur;
            end
        end else if (Restart_i) begin
            cnt_d = '0;
            idx_d = '0;
        end
        Color_o = bar_color(idx_cur);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/vga_pixel_sched.sv
// Pixel-source scheduler feeding VGA_CTRL: one pixel per Data_Req from bars, stream, underrun color or black.
module vga_pixel_sched
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE       = VGA_H_ACTIVE,
    parameter int          V_ACTIVE       = VGA_V_ACTIVE,
    parameter bit          VS_POL         = 1'b0,
    parameter logic [23:0] UNDERRUN_COLOR = 24'h808080
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Data_Req,
    input  logic        VGA_VS,
    input  logic [1:0]  Mode,
    input  logic [10:0] Win_X0,
    input  logic [10:0] Win_Y0,
    input  logic [10:0] Win_W,
    input  logic [10:0] Win_H,
    input  logic [23:0] St_Data,
    input  logic        St_Valid,
    output logic        St_Ready,
    output logic [23:0] DATA,
    output logic        Underrun,
    output logic [15:0] Frame_Underruns
);

    logic        vs_q, fs;
    mode_e       mode_q, mode_cur;
    logic [10:0] wx0_q, wy0_q, ww_q, wh_q;
    logic [10:0] wx0_cur, wy0_cur, ww_cur, wh_cur;
    logic [10:0] x_q, x_d, x_cur, y_q, y_d, y_cur;
    logic [11:0] x_end, y_end;
    logic        in_win, stream_sel, starve;
    logic [23:0] data_q, data_d, bar_rgb;
    logic        und_q, und_d;
    logic [15:0] run_q, run_d, run_base, fund_q, fund_d;

    // Frame start fires the cycle VGA_VS is first sampled at its new level.
    assign fs = VS_POL ? (!vs_q && VGA_VS) : (vs_q && !VGA_VS);

    // A request coincident with frame start already sees the new config at (0,0).
    assign mode_cur = fs ? mode_e'(Mode) : mode_q;
    assign wx0_cur  = fs ? Win_X0 : wx0_q;
    assign wy0_cur  = fs ? Win_Y0 : wy0_q;
    assign ww_cur   = fs ? Win_W  : ww_q;
    assign wh_cur   = fs ? Win_H  : wh_q;
    assign x_cur    = fs ? '0 : x_q;
    assign y_cur    = fs ? '0 : y_q;

    assign x_end  = {1'b0, wx0_cur} + {1'b0, ww_cur};
    assign y_end  = {1'b0, wy0_cur} + {1'b0, wh_cur};
    assign in_win = (x_cur >= wx0_cur) && ({1'b0, x_cur} < x_end) &&
                    (y_cur >= wy0_cur) && ({1'b0, y_cur} < y_end);

    assign stream_sel = (mode_cur == MODE_STREAM) || ((mode_cur == MODE_WIN) && in_win);
    assign St_Ready   = Data_Req && stream_sel;
    assign starve     = St_Ready && !St_Valid;

    vga_bar_pattern #(
        .BAR_W(H_ACTIVE / 8)
    ) u_bars (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Adv_i    (Data_Req),
        .Restart_i(x_cur == '0),
        .Color_o  (bar_rgb)
    );

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        data_d   = data_q;
        und_d    = und_q || starve;
        run_base = fs ? '0 : run_q;
        run_d    = (starve && run_base != 16'hFFFF) ? run_base + 16'd1 : run_base;
        fund_d   = fs ? run_q : fund_q;
        if (Data_Req) begin
            if (x_cur == 11'(H_ACTIVE - 1)) begin
                x_d = '0;
                y_d = (y_cur == 11'(V_ACTIVE - 1)) ? '0 : y_cur + 11'd1;
            end else begin
                x_d = x_cur + 11'd1;
                y_d = y_cur;
            end
            if (stream_sel)
                data_d = St_Valid ? St_Data : UNDERRUN_COLOR;
            else if (mode_cur == MODE_BLACK)
                data_d = 24'h000000;
            else
                data_d = bar_rgb;
        end else if (fs) begin
            x_d = '0;
            y_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_q   <= ~VS_POL;
            mode_q <= MODE_BARS;
            wx0_q  <= '0;
            wy0_q  <= '0;
            ww_q   <= '0;
            wh_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            data_q <= '0;
            und_q  <= 1'b0;
            run_q  <= '0;
            fund_q <= '0;
        end else begin
            vs_q   <= VGA_VS;
            mode_q <= mode_cur;
            wx0_q  <= wx0_cur;
            wy0_q  <= wy0_cur;
            ww_q   <= ww_cur;
            wh_q   <= wh_cur;
            x_q    <= x_d;
            y_q    <= y_d;
            data_q <= data_d;
            und_q  <= und_d;
            run_q  <= run_d;
            fund_q <= fund_d;
        end
    end

    assign DATA            = data_q;
    assign Underrun        = und_q;
    assign Frame_Underruns = fund_q;

endmodule

// File: tb/tb_vga_pixel_sched.sv
// Directed bench for vga_pixel_sched: bars, windowed stream, underrun, shadowing, frame-start and reset cases.
module tb_vga_pixel_sched;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Data_Req = 1'b0;
    logic        VGA_VS = 1'b1;
    logic [1:0]  Mode = 2'd0;
    logic [10:0] Win_X0 = '0, Win_Y0 = '0, Win_W = '0, Win_H = '0;
    logic [23:0] St_Data = '0;
    logic        St_Valid = 1'b0;
    logic        St_Ready;
    logic [23:0] DATA;
    logic        Underrun;
    logic [15:0] Frame_Underruns;

    int n_cmp = 0;
    int n_bad = 0;
    int st_cnt = 0;
    int beats = 0;

    vga_pixel_sched dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Data_Req       (Data_Req),
        .VGA_VS         (VGA_VS),
        .Mode           (Mode),
        .Win_X0         (Win_X0),
        .Win_Y0         (Win_Y0),
        .Win_W          (Win_W),
        .Win_H          (Win_H),
        .St_Data        (St_Data),
        .St_Valid       (St_Valid),
        .St_Ready       (St_Ready),
        .DATA           (DATA),
        .Underrun       (Underrun),
        .Frame_Underruns(Frame_Underruns)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] bar_exp(input int x);
        case (x / 80)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Called at posedge+1; issues one request and returns at the following posedge+1.
    task automatic pix(input logic vld, output logic rdy);
        logic cons;
        Data_Req = 1'b1;
        St_Valid = vld;
        #1;
        rdy  = St_Ready;
        cons = St_Ready && vld;
        @(posedge Clk);
        #1;
        if (cons) begin
            beats++;
            st_cnt++;
            St_Data = 24'(st_cnt);
        end
    endtask

    task automatic idle();
        Data_Req = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_start();
        VGA_VS = 1'b0;
        idle();
        VGA_VS = 1'b1;
        idle();
    endtask

    initial begin
        logic        r;
        int          bad, rbad, fx, fy;
        logic [23:0] d_first, d_99, d_164, d_last, d_hold;

        // Reset
        #2;
        chk("reset_data", DATA, 24'h0);
        chk("reset_ready", St_Ready, 1'b0);
        chk("reset_underrun", Underrun, 1'b0);
        chk("reset_frame_und", Frame_Underruns, 16'h0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        idle();

        // Mode 0: one full line of bars
        Mode = 2'd0;
        frame_start();
        bad = 0;
        rbad = 0;
        for (int x = 0; x < 640; x++) begin
            pix(1'b1, r);
            if (r !== 1'b0) rbad++;
            if (DATA !== bar_exp(x)) bad++;
            if (x == 79) chk("bars_x79", DATA, 24'hFFFFFF);
            if (x == 80) chk("bars_x80", DATA, 24'hFFFF00);
        end
        chk("bars_line_errors", bad, 0);
        chk("bars_ready_never", rbad, 0);
        chk("bars_x639", DATA, 24'h000000);
        d_hold = DATA;
        pix(1'b1, r);
        chk("bars_next_line_x0", DATA, 24'hFFFFFF);
        idle();
        idle();
        chk("idle_hold", DATA, 24'hFFFFFF);

        // Mode 2: windowed stream (100,50,64,32), St_Valid always high
        Mode = 2'd2;
        Win_X0 = 11'd100; Win_Y0 = 11'd50; Win_W = 11'd64; Win_H = 11'd32;
        frame_start();
        beats = 0; bad = 0; rbad = 0; fx = -1; fy = -1;
        d_first = '0; d_99 = '0; d_164 = '0; d_last = '0;
        for (int y = 0; y < 82; y++) begin
            for (int x = 0; x < 640; x++) begin
                logic w;
                w = (x >= 100) && (x < 164) && (y >= 50) && (y < 82);
                pix(1'b1, r);
                if (r !== w) rbad++;
                if (r === 1'b1 && fx < 0) begin fx = x; fy = y; end
                if (!w && DATA !== bar_exp(x)) bad++;
                if (x == 100 && y == 50) d_first = DATA;
                if (x == 99  && y == 50) d_99 = DATA;
                if (x == 164 && y == 50) d_164 = DATA;
                if (x == 163 && y == 81) d_last = DATA;
            end
        end
        Data_Req = 1'b0;
        chk("win_beats", beats, 2048);
        chk("win_first_x", fx, 100);
        chk("win_first_y", fy, 50);
        chk("win_first_data", d_first, 24'h000000);
        chk("win_last_data", d_last, 24'h0007FF);
        chk("win_x99_bar", d_99, 24'hFFFF00);
        chk("win_x164_bar", d_164, 24'h00FFFF);
        chk("win_ready_pattern", rbad, 0);
        chk("win_outside_bars", bad, 0);
        chk("win_no_underrun", Underrun, 1'b0);

        // Mode 1: five starved requests
        Mode = 2'd1;
        frame_start();
        beats = 0; bad = 0; rbad = 0;
        for (int i = 0; i < 3; i++) pix(1'b1, r);
        chk("und_pre_data", DATA, 24'h000802);
        for (int i = 0; i < 5; i++) begin
            pix(1'b0, r);
            if (r !== 1'b1) rbad++;
            if (DATA !== 24'h808080) bad++;
        end
        chk("und_color_5th", DATA, 24'h808080);
        chk("und_color_all", bad, 0);
        chk("und_ready_high", rbad, 0);
        chk("und_flag", Underrun, 1'b1);
        for (int i = 0; i < 2; i++) pix(1'b1, r);
        chk("und_resume_data", DATA, 24'h000804);
        chk("und_beats", beats, 5);
        chk("und_frame_before", Frame_Underruns, 16'd0);
        Data_Req = 1'b0;
        frame_start();
        chk("und_frame_after", Frame_Underruns, 16'd5);
        chk("und_sticky", Underrun, 1'b1);

        // Config shadowing: 0 -> 3 mid-frame
        Mode = 2'd0;
        frame_start();
        chk("shadow_frame_cleared", Frame_Underruns, 16'd0);
        for (int i = 0; i < 10; i++) pix(1'b1, r);
        Mode = 2'd3;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            pix(1'b1, r);
            if (DATA !== 24'hFFFFFF) bad++;
        end
        chk("shadow_bars_continue", bad, 0);
        Data_Req = 1'b0;
        frame_start();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            pix(1'b1, r);
            if (DATA !== 24'h000000) bad++;
        end
        chk("shadow_black", bad, 0);

        // Coincident frame start and request
        Mode = 2'd0;
        VGA_VS = 1'b0;
        pix(1'b1, r);
        chk("coinc_data", DATA, 24'hFFFFFF);
        chk("coinc_next_x", dut.x_q, 32'd1);
        VGA_VS = 1'b1;
        for (int i = 0; i < 98; i++) pix(1'b1, r);
        chk("coinc_x98", DATA, 24'hFFFF00);
        Data_Req = 1'b0;

        // Reset mid-line
        Reset_n = 1'b0;
        #2;
        chk("rst_mid_data", DATA, 24'h0);
        chk("rst_mid_underrun", Underrun, 1'b0);
        chk("rst_mid_ready", St_Ready, 1'b0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        idle();
        for (int i = 0; i < 80; i++) pix(1'b1, r);
        chk("rst_after_x79", DATA, 24'hFFFFFF);
        pix(1'b1, r);
        chk("rst_after_x80", DATA, 24'hFFFF00);
        Data_Req = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
